seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
- Round-robin scheduler that shares one serial Moore 1011 sequence detector (non-overlapping) among NCH serial bit-stream requesters.
- Grants the detector to one channel per burst and clears the detector between bursts, so partial matches never leak across channels.
- Muxes the granted channel's bits into the detector and attributes each detection to the granted channel.
- Keeps a saturating per-channel hit counter.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- MAX_BURST, 16, max bits accepted per grant before forced preemption.
- CW, 8, width of each per-channel hit counter.
- TIMEOUT, 32, idle-valid cycles before abort (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- clr_i  in  1  asynchronous, active-high reset.
- req_i  in  NCH  per-channel burst request (level).
- ch_valid_i  in  NCH  per-channel bit valid.
- bit_i  in  NCH  per-channel serial bit.
- last_i  in  NCH  marks the final bit of a burst, qualified by valid&ready.
- ch_ready_o  out  NCH  one-hot; the bit is accepted when valid&ready.
- gnt_o  out  NCH  one-hot grant to the current owner.
- det_clr_o  out  1  synchronous clear pulse to the detector.
- det_valid_o  out  1  detector valid_i drive.
- det_input_o  out  1  detector input_i drive.
- det_out_i  in  1  detector Moore output.
- hit_o  out  NCH  one-cycle detection pulse per channel.
- cnt_clr_i  in  1  synchronous clear of all counters.
- hit_cnt_o  out  NCH*CW  packed counters; channel k at [k*CW +: CW].
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: clr_i high asynchronously forces IDLE.
  - gnt_o=0, ch_ready_o=0, det_clr_o=0, det_valid_o=0, det_input_o=0, hit_o=0, all counters=0, busy_o=0.
  - RR pointer=0, burst count=0, det_out_q=0.
  - Assertion mid-burst aborts the burst; no hit is counted.
- FSM states: IDLE, CLEAR, STREAM, DRAIN.
- IDLE:
  - If any req_i is set, select the first requester at or after the RR pointer, register its one-hot grant, and go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR (1 cycle):
  - gnt_o holds the owner; det_clr_o=1; ch_ready_o=0; det_out_q cleared; burst count=0.
  - Next state: STREAM.
- STREAM:
  - ch_ready_o = gnt_o.
  - det_valid_o = ch_valid_i[g] and det_input_o = bit_i[g], combinational, zero latency. Both are 0 outside STREAM.
  - Each accepted bit increments the burst count.
  - Go to DRAIN on whichever comes first: an accepted bit with last_i[g], or the MAX_BURST-th accepted bit.
  - Owner drops req_i with no bit in flight: go to DRAIN.
- DRAIN (1 cycle):
  - ch_ready_o=0; gnt_o is held so the Moore output for the final bit can be attributed.
  - RR pointer becomes g+1 mod NCH.
  - Next: arbitrate as in IDLE and go to CLEAR, or go to IDLE if no request is pending.
- Detection and attribution:
  - det_out_q registers det_out_i every cycle.
  - A rise (det_out_i & ~det_out_q) during STREAM or DRAIN sets hit_o[g] to 1 on the next cycle, for one cycle.
  - The attributed channel is the owner at the rise. This holds even if the grant changes on the same edge.
  - Rises in IDLE or CLEAR are ignored.
- Counters:
  - A hit increments that channel's counter, saturating at 2^CW-1.
  - cnt_clr_i clears all counters. If a hit coincides with cnt_clr_i, the counter becomes 1.
- Grant switching:
  - At most one bit of any channel is in flight.
  - The minimum gap between bursts is 2 cycles (DRAIN, CLEAR).
  - A non-owner's valid/bit inputs are ignored.

Optional Feature:
- Macro: SEQ_DET_TIMEOUT_EN.
- Defined: in STREAM, a counter of consecutive cycles with ch_valid_i[g]=0 reaches TIMEOUT.
  - Go to DRAIN and pulse abort_o (extra 1-bit output, reset 0) for one cycle.
  - The counter resets on every accepted bit.
- Undefined: no abort_o port and no timer; a stalled owner holds the grant until last_i, MAX_BURST, or req_i drop.

Decomposition:
- Package seq_det_pkg:
  - state enum (IDLE, CLEAR, STREAM, DRAIN);
  - localparam for burst-count width, $clog2(MAX_BURST+1);
  - function next_rr(req, ptr) returning a one-hot grant.
- Sub-module rr_arbiter (NCH-wide, pointer-based, combinational grant with a registered pointer), instantiated once.

Test Plan (NCH=2, MAX_BURST=8, CW=8, with the 1011 Moore detector attached):
- Ch0 requests and sends 1,0,1,1 with last on the 4th bit.
  - gnt_o=01 from the cycle after req, det_clr_o pulses once.
  - hit_o[0] pulses 2 cycles after the 4th bit is accepted; hit_cnt0=1.
- Both channels request from IDLE.
  - Ch0 is served first, then ch1 after DRAIN and CLEAR.
  - Ch1 sends 1,0,1,1,1,0,1,1: hit_cnt1=2, hit_cnt0 unchanged.
- Ch0 streams 12 bits with no last while ch1 is requesting.
  - Ch0 is preempted after the 8th accepted bit; ch1 is granted next.
  - Ch0 is regranted afterwards and its remaining 4 bits are accepted.
- Pattern split across channels: ch0 sends 1,0 with last; ch1 sends 1,1.
  - No hit; det_clr_o pulses between the bursts.
- clr_i asserted mid-STREAM after 3 bits of 1011.
  - Outputs zero immediately; no hit_o; counters=0; FSM in IDLE after release.
- Saturation: CW=2, five 1011 detections on ch0 -> hit_cnt0=3.
  - cnt_clr_i coincident with a hit -> hit_cnt0=1.

Source files
------------

// File: rtl/seq_det_sched_pkg.sv
// Shared types and helpers for the round-robin 1011-detector scheduler.
package seq_det_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

  localparam int NCH_MAX       = 8;
  localparam int MAX_BURST_DEF = 16;

  // Burst counter must be able to hold MAX_BURST itself.
  function automatic int bcnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // First requester at or after ptr, as a one-hot over the low n bits.
  function automatic logic [NCH_MAX-1:0] next_rr(input logic [NCH_MAX-1:0] req,
                                                 input int ptr, input int n);
    logic [2:0] idx;
    next_rr = '0;
    for (int i = 0; i < NCH_MAX; i++) begin
      idx = 3'((ptr + i) % n);
      if (i < n && req[idx] && next_rr == '0) next_rr[idx] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational grant, registered pointer.
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic           clk_i,
  input  logic           clr_i,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  input  logic [NCH-1:0] owner,
  output logic [NCH-1:0] gnt
);

  localparam int PW = $clog2(NCH);

  logic [PW-1:0] ptr_q;
  int            owner_idx;
  int            eff_ptr;

  // While advancing, arbitrate against owner+1 so the owner is not favoured.
  always_comb begin
    owner_idx = 0;
    for (int k = 0; k < NCH; k++)
      if (owner[k]) owner_idx = k;
    eff_ptr = adv ? (owner_idx + 1) % NCH : int'(ptr_q);
    gnt     = NCH'(next_rr(NCH_MAX'(req), eff_ptr, NCH));
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i)    ptr_q <= '0;
    else if (adv) ptr_q <= PW'(eff_ptr);
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one Moore 1011 detector among NCH serial requesters, round-robin per burst.
// Optional stall abort: define SEQ_DET_TIMEOUT_EN to add the idle timer and abort_o.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CW        = 8
`ifdef SEQ_DET_TIMEOUT_EN
  , parameter int TIMEOUT = 32
`endif
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH-1:0]    ch_valid_i,
  input  logic [NCH-1:0]    bit_i,
  input  logic [NCH-1:0]    last_i,
  output logic [NCH-1:0]    ch_ready_o,
  output logic [NCH-1:0]    gnt_o,
  output logic              det_clr_o,
  output logic              det_valid_o,
  output logic              det_input_o,
  input  logic              det_out_i,
  output logic [NCH-1:0]    hit_o,
  input  logic              cnt_clr_i,
  output logic [NCH*CW-1:0] hit_cnt_o,
  output logic              busy_o
`ifdef SEQ_DET_TIMEOUT_EN
  , output logic            abort_o
`endif
);

  // state  | meaning
  // IDLE   | no owner, waiting for any request
  // CLEAR  | owner granted, detector being cleared
  // STREAM | owner's bits routed to the detector
  // DRAIN  | owner held one cycle so its last detection is attributed

  localparam int BCW = bcnt_w(MAX_BURST);

  state_t         state;
  logic [BCW-1:0] bcnt;
  logic           det_out_q;
  logic [NCH-1:0] arb_gnt;
  logic           in_stream, acc, acc_last, own_req, rise, burst_end;

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
`endif

  assign in_stream   = (state == STREAM);
  assign acc         = in_stream & |(ch_valid_i & gnt_o);
  assign acc_last    = |(last_i & gnt_o);
  assign own_req     = |(req_i & gnt_o);
  assign rise        = det_out_i & ~det_out_q;
  assign burst_end   = acc & (acc_last | (bcnt == BCW'(MAX_BURST - 1)));
  assign det_valid_o = acc;
  assign det_input_o = in_stream & |(bit_i & gnt_o);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk_i (clk_i),
    .clr_i (clr_i),
    .req   (req_i),
    .adv   (state == DRAIN),
    .owner (gnt_o),
    .gnt   (arb_gnt)
  );

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state      <= IDLE;
      gnt_o      <= '0;
      ch_ready_o <= '0;
      det_clr_o  <= 1'b0;
      hit_o      <= '0;
      busy_o     <= 1'b0;
      bcnt       <= '0;
      det_out_q  <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
      abort_o    <= 1'b0;
      tmr        <= '0;
`endif
    end else begin
      det_out_q <= (state == CLEAR) ? 1'b0 : det_out_i;
      // gnt_o still names the owner at the rise, even if it changes on this edge.
      hit_o     <= (rise && (state == STREAM || state == DRAIN)) ? gnt_o : '0;
      det_clr_o <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
      abort_o   <= 1'b0;
`endif
      case (state)
        IDLE, DRAIN: begin
          if (|req_i) begin
            gnt_o     <= arb_gnt;
            det_clr_o <= 1'b1;
            busy_o    <= 1'b1;
            state     <= CLEAR;
          end else begin
            gnt_o  <= '0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        CLEAR: begin
          bcnt       <= '0;
          ch_ready_o <= gnt_o;
          state      <= STREAM;
`ifdef SEQ_DET_TIMEOUT_EN
          tmr        <= TW'(TIMEOUT - 1);
`endif
        end
        STREAM: begin
          if (acc) begin
            bcnt <= bcnt + BCW'(1);
`ifdef SEQ_DET_TIMEOUT_EN
            tmr  <= TW'(TIMEOUT - 1);
`endif
            if (burst_end) begin
              ch_ready_o <= '0;
              state      <= DRAIN;
            end
          end else if (!own_req) begin
            ch_ready_o <= '0;
            state      <= DRAIN;
          end
`ifdef SEQ_DET_TIMEOUT_EN
          else if (tmr == '0) begin
            ch_ready_o <= '0;
            abort_o    <= 1'b1;
            state      <= DRAIN;
          end else begin
            tmr <= tmr - TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A hit landing together with a clear leaves the count at one.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      hit_cnt_o <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cnt_clr_i)
          hit_cnt_o[k*CW +: CW] <= hit_o[k] ? CW'(1) : '0;
        else if (hit_o[k] && hit_cnt_o[k*CW +: CW] != {CW{1'b1}})
          hit_cnt_o[k*CW +: CW] <= hit_cnt_o[k*CW +: CW] + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed and random bursts on a 2-channel scheduler with an attached 1011 Moore detector.
module tb_seq_det_sched;

  localparam int NCH = 2;
  localparam int MB  = 8;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  typedef bit bq_t[$];

  logic              clk_i = 1'b0;
  logic              clr_i;
  logic [NCH-1:0]    req_i, ch_valid_i, bit_i, last_i;
  logic [NCH-1:0]    ch_ready_o, gnt_o, hit_o;
  logic              det_clr_o, det_valid_o, det_input_o, det_out_i;
  logic              cnt_clr_i, busy_o;
  logic [NCH*CW-1:0] hit_cnt_o;
`ifdef SEQ_DET_TIMEOUT_EN
  logic              abort_o;
`endif

  int n_cmp = 0, n_bad = 0;
  int exp_cnt[NCH], exp_hits[NCH], seen_hits[NCH];
  int exp_clr, seen_clr;

  seq_det_sched #(.NCH(NCH), .MAX_BURST(MB), .CW(CW)) dut (
    .clk_i       (clk_i),
    .clr_i       (clr_i),
    .req_i       (req_i),
    .ch_valid_i  (ch_valid_i),
    .bit_i       (bit_i),
    .last_i      (last_i),
    .ch_ready_o  (ch_ready_o),
    .gnt_o       (gnt_o),
    .det_clr_o   (det_clr_o),
    .det_valid_o (det_valid_o),
    .det_input_o (det_input_o),
    .det_out_i   (det_out_i),
    .hit_o       (hit_o),
    .cnt_clr_i   (cnt_clr_i),
    .hit_cnt_o   (hit_cnt_o),
    .busy_o      (busy_o)
`ifdef SEQ_DET_TIMEOUT_EN
    , .abort_o   (abort_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Attached detector: Moore, non-overlapping 1011, synchronous clear.
  logic [2:0] dst;
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i)            dst <= 3'd0;
    else if (det_clr_o)   dst <= 3'd0;
    else if (det_valid_o) begin
      case (dst)
        3'd0:    dst <= det_input_o ? 3'd1 : 3'd0;
        3'd1:    dst <= det_input_o ? 3'd1 : 3'd2;
        3'd2:    dst <= det_input_o ? 3'd3 : 3'd0;
        3'd3:    dst <= det_input_o ? 3'd4 : 3'd2;
        default: dst <= det_input_o ? 3'd1 : 3'd0;
      endcase
    end
  end
  assign det_out_i = (dst == 3'd4);

  always @(negedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      for (int k = 0; k < NCH; k++) seen_hits[k] = 0;
      seen_clr = 0;
    end else begin
      for (int k = 0; k < NCH; k++) seen_hits[k] += int'(hit_o[k]);
      if (det_clr_o) seen_clr++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bq_t pat(input logic [31:0] v, input int n);
    bq_t q;
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  // Leftmost, non-overlapping occurrences of 1011 in a bit string.
  function automatic int count_1011(input bq_t b);
    int c = 0;
    int i = 0;
    while (i + 3 < b.size()) begin
      if (b[i] && !b[i+1] && b[i+2] && b[i+3]) begin
        c++;
        i += 4;
      end else begin
        i++;
      end
    end
    return c;
  endfunction

  // A burst is served in grants of at most MB bits; each grant starts clean.
  task automatic model_burst(input int ch, input bq_t b);
    bq_t seg;
    int  h;
    for (int s = 0; s < b.size(); s += MB) begin
      seg.delete();
      for (int j = s; j < s + MB && j < b.size(); j++) seg.push_back(b[j]);
      h = count_1011(seg);
      exp_hits[ch] += h;
      exp_cnt[ch] = (exp_cnt[ch] + h > SAT) ? SAT : exp_cnt[ch] + h;
      exp_clr++;
    end
  endtask

  task automatic stream_bits(input int ch, input bq_t b, input bit do_last, input bit account);
    int oth = 1 - ch;
    bit acc;
    int w;
    req_i[ch] = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 64) begin
        ch_valid_i[ch] = 1'b1;
        bit_i[ch]      = b[i];
        last_i[ch]     = do_last && (i == b.size() - 1);
        if (gnt_o[ch]) begin
          ch_valid_i[oth] = 1'($urandom_range(0, 1));
          bit_i[oth]      = 1'($urandom_range(0, 1));
          last_i[oth]     = 1'($urandom_range(0, 1));
        end else begin
          ch_valid_i[oth] = 1'b0;
          last_i[oth]     = 1'b0;
        end
        #1;
        if (ch_ready_o[ch]) begin
          chk("det_valid", 32'(det_valid_o), 32'd1);
          chk("det_input", 32'(det_input_o), 32'(b[i]));
          acc = 1'b1;
        end
        tick();
        w++;
      end
      chk("accept_wait", 32'(acc), 32'd1);
      if (do_last && i == b.size() - 1) req_i[ch] = 1'b0;
    end
    ch_valid_i = '0;
    last_i     = '0;
    bit_i      = '0;
    if (account) model_burst(ch, b);
  endtask

  task automatic check_model(input string tag);
    repeat (3) tick();
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("%s_cnt%0d", tag, k), 32'(hit_cnt_o[k*CW +: CW]), 32'(exp_cnt[k]));
      chk($sformatf("%s_hits%0d", tag, k), 32'(seen_hits[k]), 32'(exp_hits[k]));
    end
    chk({tag, "_clr_pulses"}, 32'(seen_clr), 32'(exp_clr));
  endtask

  task automatic zero_model();
    for (int k = 0; k < NCH; k++) begin
      exp_cnt[k]  = 0;
      exp_hits[k] = 0;
    end
    exp_clr = 0;
  endtask

  initial begin
    bq_t rb;
    int  ch, n;
    logic [3:0] nib;

    clr_i = 1'b1; req_i = '0; ch_valid_i = '0; bit_i = '0; last_i = '0; cnt_clr_i = 1'b0;
    zero_model();
    repeat (2) tick();
    chk("rst_gnt",   32'(gnt_o),       32'd0);
    chk("rst_ready", 32'(ch_ready_o),  32'd0);
    chk("rst_dclr",  32'(det_clr_o),   32'd0);
    chk("rst_dval",  32'(det_valid_o), 32'd0);
    chk("rst_din",   32'(det_input_o), 32'd0);
    chk("rst_hit",   32'(hit_o),       32'd0);
    chk("rst_cnt",   32'(hit_cnt_o),   32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    clr_i = 1'b0;
    tick();

    // single 1011 burst on ch0
    req_i[0] = 1'b1;
    tick();
    chk("t1_gnt",   32'(gnt_o),     32'b01);
    chk("t1_dclr",  32'(det_clr_o), 32'd1);
    chk("t1_busy",  32'(busy_o),    32'd1);
    tick();
    chk("t1_dclr_off", 32'(det_clr_o),  32'd0);
    chk("t1_ready",    32'(ch_ready_o), 32'b01);
    stream_bits(0, pat(32'hB, 4), 1'b1, 1'b1);
    chk("t1_hit_early", 32'(hit_o), 32'd0);
    tick();
    chk("t1_hit", 32'(hit_o), 32'b01);
    tick();
    chk("t1_hit_off", 32'(hit_o), 32'd0);
    check_model("t1");

    // reset in the middle of a burst
    stream_bits(0, pat(32'h5, 3), 1'b0, 1'b0);
    clr_i = 1'b1;
    #1;
    chk("t5_gnt",   32'(gnt_o),       32'd0);
    chk("t5_ready", 32'(ch_ready_o),  32'd0);
    chk("t5_dval",  32'(det_valid_o), 32'd0);
    chk("t5_busy",  32'(busy_o),      32'd0);
    chk("t5_cnt",   32'(hit_cnt_o),   32'd0);
    req_i = '0;
    zero_model();
    tick();
    clr_i = 1'b0;
    repeat (4) tick();
    chk("t5_idle",  32'(busy_o), 32'd0);
    chk("t5_nohit", 32'(seen_hits[0]), 32'd0);

    // both request from IDLE: ch0 first, then ch1
    req_i = 2'b11;
    tick();
    chk("t2_gnt0", 32'(gnt_o), 32'b01);
    stream_bits(0, pat(32'h6, 4), 1'b1, 1'b1);
    stream_bits(1, pat(32'hBB, 8), 1'b1, 1'b1);
    check_model("t2");

    // forced preemption after MB bits, detection on the switching edge
    req_i = 2'b11;
    stream_bits(0, pat(32'h6B, 8), 1'b0, 1'b1);
    chk("t3_ready_drop", 32'(ch_ready_o), 32'd0);
    chk("t3_drain_hold", 32'(gnt_o),      32'b01);
    tick();
    chk("t3_gnt1",   32'(gnt_o), 32'b10);
    chk("t3_hit_ch0", 32'(hit_o), 32'b01);
    stream_bits(1, pat(32'hB, 4), 1'b1, 1'b1);
    stream_bits(0, pat(32'hB, 4), 1'b1, 1'b1);
    check_model("t3");

    // pattern split across channels must not match
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    for (int k = 0; k < NCH; k++) exp_cnt[k] = 0;
    chk("t4_cnt_clr", 32'(hit_cnt_o), 32'd0);
    stream_bits(0, pat(32'h2, 2), 1'b1, 1'b1);
    stream_bits(1, pat(32'h3, 2), 1'b1, 1'b1);
    check_model("t4");

    // saturation, then clear coincident with a hit
    stream_bits(0, pat(32'hBBBBB, 20), 1'b1, 1'b1);
    check_model("t6");
    stream_bits(0, pat(32'hB, 4), 1'b1, 1'b1);
    tick();
    chk("t6_hit", 32'(hit_o), 32'b01);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    exp_cnt[0] = 1;
    exp_cnt[1] = 0;
    chk("t6_clr_coincide", 32'(hit_cnt_o[CW-1:0]), 32'd1);
    check_model("t6b");

    // random bursts
    for (int it = 0; it < 25; it++) begin
      ch = int'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 12));
      rb.delete();
      while (rb.size() < n) begin
        nib = ($urandom_range(0, 1) == 0) ? 4'hB : 4'($urandom_range(0, 15));
        for (int j = 3; j >= 0 && rb.size() < n; j--) rb.push_back(nib[j]);
      end
      stream_bits(ch, rb, 1'b1, 1'b1);
      if ($urandom_range(0, 4) == 0) begin
        repeat (3) tick();
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        for (int k = 0; k < NCH; k++) exp_cnt[k] = 0;
      end
      check_model($sformatf("rnd%0d", it));
    end
    chk("end_idle", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
